// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit types, line levels and frame-length helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam logic LINE_MARK  = 1'b1;
    localparam logic LINE_SPACE = 1'b0;
    function automatic int uart_frame_bits(input int data_bits, input int parity_en, input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction
endpackage

// File: rtl/parity_d.sv
// parity_d: combinational even/odd parity generator; outputs 0 when parity is disabled
module parity_d #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 1,
    parameter int PARITY_TYPE = 0
) (
    input  logic [DATA_BITS-1:0] data,
    output logic                 parity
);
    assign parity = (PARITY_EN != 0) && ((^data) ^ (PARITY_TYPE != 0));
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: valid/ready UART transmitter framing start, LSB-first data, optional parity and stop bits
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_TYPE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_ctrl: DATA_BITS must be 5..9");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
        $error("uart_tx_ctrl: PARITY_EN must be 0 or 1");
    end
    if (PARITY_TYPE != 0 && PARITY_TYPE != 1) begin : g_bad_parity_type
        $error("uart_tx_ctrl: PARITY_TYPE must be 0 or 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
    end

    tx_state_t            state, state_d;
    logic [CW-1:0]        baud, baud_d;
    logic [BW-1:0]        bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic                 par, par_d, par_gen, done_d, ser_d, bit_end;

    parity_d #(
        .DATA_BITS  (DATA_BITS),
        .PARITY_EN  (PARITY_EN),
        .PARITY_TYPE(PARITY_TYPE)
    ) u_parity (
        .data  (tx_data),
        .parity(par_gen)
    );

    assign bit_end  = baud == BAUD_LAST;
    assign tx_ready = state == IDLE;
    assign tx_busy  = state != IDLE;

    always_comb begin
        state_d = state;
        baud_d  = (state == IDLE || bit_end) ? '0 : baud + 1'b1;
        bit_d   = bit_cnt;
        shift_d = shift;
        par_d   = par;
        done_d  = 1'b0;
        case (state)
            IDLE: if (tx_valid) begin
                state_d = START;
                shift_d = tx_data;
                par_d   = par_gen;
                bit_d   = '0;
            end
            START: if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                shift_d = shift >> 1;
                bit_d   = (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                if (bit_cnt == DATA_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: if (bit_end) begin
                bit_d = (bit_cnt == STOP_LAST) ? '0 : bit_cnt + 1'b1;
                if (bit_cnt == STOP_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level is computed for the upcoming cycle so tx_serial can be a plain flop
        ser_d = (state_d == START)  ? LINE_SPACE :
                (state_d == DATA)   ? shift_d[0] :
                (state_d == PARITY) ? par_d : LINE_MARK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud      <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par       <= 1'b0;
            tx_serial <= LINE_MARK;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_d;
            baud      <= baud_d;
            bit_cnt   <= bit_d;
            shift     <= shift_d;
            par       <= par_d;
            tx_serial <= ser_d;
            tx_done   <= done_d;
        end
    end
endmodule
